// File: rtl/jk_command_encoder.sv
// Turns a stream of desired flop values (bytes, MSB first) into JK commands for an
// external flop, tracking its value so only necessary changes are issued.
module jk_command_encoder #(
  parameter int DEPTH      = 4,
  parameter bit USE_TOGGLE = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  input  logic       resync,
  output logic [1:0] j,
  output logic       j_valid,
  output logic       model_q,
  output logic       byte_done,
  output logic       busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   ONE_COUNT  = (AW+1)'(1'b1);
  localparam logic [AW:0]   ZERO_COUNT = (AW+1)'(1'b0);
  localparam logic [AW-1:0] ONE_PTR    = AW'(1'b1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  localparam logic [1:0] CMD_HOLD   = 2'b00;
  localparam logic [1:0] CMD_RESET  = 2'b01;
  localparam logic [1:0] CMD_SET    = 2'b10;
  localparam logic [1:0] CMD_TOGGLE = 2'b11;

  logic [7:0]    fifo_mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic [0:0]    state_r;
  logic [7:0]    shift_r;
  logic [2:0]    bit_cnt_r;
  logic          known_r;

  logic          push_s;
  logic          pop_s;
  logic          fifo_empty_s;
  logic          last_bit_s;
  logic          desired_s;
  logic [7:0]    head_s;
  logic [1:0]    cmd_s;

  function automatic logic [1:0] explicit_cmd(input logic d);
    logic [1:0] c;
    if (d) begin
      c = CMD_SET;
    end else begin
      c = CMD_RESET;
    end
    return c;
  endfunction

  function automatic logic apply_cmd(input logic [1:0] cmd, input logic q);
    logic r;
    case (cmd)
      CMD_RESET:  r = 1'b0;
      CMD_SET:    r = 1'b1;
      CMD_TOGGLE: r = ~q;
      default:    r = q;
    endcase
    return r;
  endfunction

  assign in_ready = (count_r != FULL_COUNT);

  // Handshake decode and command selection for the bit currently at the shifter MSB
  always_comb begin
    push_s       = in_valid && in_ready;
    fifo_empty_s = (count_r == ZERO_COUNT);
    last_bit_s   = (bit_cnt_r == 3'd0);
    pop_s        = !fifo_empty_s && ((state_r == ST_IDLE) ||
                                     ((state_r == ST_SHIFT) && last_bit_s));
    head_s       = fifo_mem_r[rd_ptr_r];
    desired_s    = shift_r[7];
    // An unknown flop must be driven explicitly before toggles can be trusted again
    if (!known_r) begin
      cmd_s = explicit_cmd(desired_s);
    end else if (desired_s == model_q) begin
      cmd_s = CMD_HOLD;
    end else if (USE_TOGGLE) begin
      cmd_s = CMD_TOGGLE;
    end else begin
      cmd_s = explicit_cmd(desired_s);
    end
  end

  // Pattern FIFO storage
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= in_data;
    end
  end

  // Pattern FIFO pointers and occupancy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= ZERO_COUNT;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + ONE_PTR;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + ONE_PTR;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + ONE_COUNT;
        2'b01:   count_r <= count_r - ONE_COUNT;
        default: count_r <= count_r;
      endcase
    end
  end

  // Serializer FSM, command outputs and flop model
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= ST_IDLE;
      shift_r   <= 8'h00;
      bit_cnt_r <= 3'd0;
      j         <= CMD_HOLD;
      j_valid   <= 1'b0;
      byte_done <= 1'b0;
      model_q   <= 1'b0;
      known_r   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      busy <= (state_r == ST_SHIFT) || !fifo_empty_s;
      case (state_r)
        ST_IDLE: begin
          j         <= CMD_HOLD;
          j_valid   <= 1'b0;
          byte_done <= 1'b0;
          known_r   <= known_r && !resync;
          if (pop_s) begin
            shift_r   <= head_s;
            bit_cnt_r <= 3'd7;
            state_r   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          j         <= cmd_s;
          j_valid   <= 1'b1;
          byte_done <= last_bit_s;
          model_q   <= apply_cmd(cmd_s, model_q);
          // The command computed this cycle still goes out; resync only affects later ones
          known_r   <= !resync;
          if (!last_bit_s) begin
            shift_r   <= {shift_r[6:0], 1'b0};
            bit_cnt_r <= bit_cnt_r - 3'd1;
          end else if (pop_s) begin
            shift_r   <= head_s;
            bit_cnt_r <= 3'd7;
          end else begin
            shift_r   <= 8'h00;
            state_r   <= ST_IDLE;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          j         <= CMD_HOLD;
          j_valid   <= 1'b0;
          byte_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jk_command_encoder.sv
// Scoreboard bench for jk_command_encoder: toggle and explicit variants run side by side.
module tb_jk_command_encoder;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_data;
  logic       resync;
  logic       ready_t, ready_e;
  logic [1:0] j_t, j_e;
  logic       jv_t, jv_e, mq_t, mq_e, bd_t, bd_e, busy_t, busy_e;

  int n_cmp = 0;
  int n_bad = 0;

  // Expected {valid,j,byte_done,model_q,busy} for toggle DUT then explicit DUT
  logic [11:0] sb[$];
  logic        tk, tqv, ek, eqv;

  always #5 clk = ~clk;

  jk_command_encoder #(.DEPTH(4), .USE_TOGGLE(1'b1)) u_tog (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(ready_t),
    .resync(resync), .j(j_t), .j_valid(jv_t), .model_q(mq_t), .byte_done(bd_t), .busy(busy_t)
  );

  jk_command_encoder #(.DEPTH(4), .USE_TOGGLE(1'b0)) u_exp (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(ready_e),
    .resync(resync), .j(j_e), .j_valid(jv_e), .model_q(mq_e), .byte_done(bd_e), .busy(busy_e)
  );

  function automatic logic [11:0] observe();
    return {jv_t, j_t, bd_t, mq_t, busy_t, jv_e, j_e, bd_e, mq_e, busy_e};
  endfunction

  task automatic reset_model();
    tk = 1'b0; tqv = 1'b0; ek = 1'b0; eqv = 1'b0;
  endtask

  // Reference model: queue the eight expected commands for byte b
  task automatic push_expect(input logic [7:0] b, input int resync_bit);
    logic d;
    logic [1:0] tc, ec;
    for (int i = 7; i >= 0; i--) begin
      d = b[i];
      if (!tk) tc = d ? 2'b10 : 2'b01;
      else if (d == tqv) tc = 2'b00;
      else tc = 2'b11;
      if (!ek || d != eqv) ec = d ? 2'b10 : 2'b01;
      else ec = 2'b00;
      tqv = (tc == 2'b11) ? ~tqv : ((tc == 2'b00) ? tqv : tc[1]);
      eqv = (ec == 2'b00) ? eqv : ec[1];
      tk = (i != resync_bit);
      ek = (i != resync_bit);
      sb.push_back({1'b1, tc, (i == 0), tqv, 1'b1, 1'b1, ec, (i == 0), eqv, 1'b1});
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b0; in_data = 8'h00; resync = 1'b0;
    reset_model();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (observe() !== 12'h000) begin
      n_bad++; $display("FAIL reset_outputs: got %b expected %b", observe(), 12'h000);
    end
    n_cmp++;
    if ({ready_t, ready_e} !== 2'b11) begin
      n_bad++; $display("FAIL reset_ready: got %b expected 11", {ready_t, ready_e});
    end
    @(negedge clk); reset = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (observe() !== 12'h000) begin
      n_bad++; $display("FAIL idle_after_release: got %b expected %b", observe(), 12'h000);
    end
  endtask

  task automatic test_single_byte();
    logic [11:0] obs, exp;
    int first_v;
    first_v = -1;
    @(negedge clk); in_valid = 1'b1; in_data = 8'hA5; push_expect(8'hA5, -1);
    @(posedge clk); #1 in_valid = 1'b0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      obs = observe();
      if (jv_t || jv_e) begin
        if (first_v < 0) first_v = c;
        exp = (sb.size() > 0) ? sb.pop_front() : 12'h000;
        n_cmp++;
        if (obs !== exp) begin
          n_bad++; $display("FAIL single_cmd c=%0d: got %b expected %b", c, obs, exp);
        end
      end
    end
    n_cmp++;
    if (first_v !== 2) begin
      n_bad++; $display("FAIL latency: got %0d cycles expected 2", first_v);
    end
    n_cmp++;
    if (sb.size() !== 0) begin
      n_bad++; $display("FAIL single_missing: got %0d left expected 0", sb.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] obs, exp;
    int nv, first_v, last_v;
    nv = 0; first_v = -1; last_v = -1;
    fork
      begin
        @(negedge clk); in_valid = 1'b1; in_data = 8'hA5; push_expect(8'hA5, -1);
        @(negedge clk); in_data = 8'hFF; push_expect(8'hFF, -1);
        @(negedge clk); in_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 26; c++) begin
          @(negedge clk);
          obs = observe();
          if (jv_t || jv_e) begin
            nv++;
            if (first_v < 0) first_v = c;
            last_v = c;
            exp = (sb.size() > 0) ? sb.pop_front() : 12'h000;
            n_cmp++;
            if (obs !== exp) begin
              n_bad++; $display("FAIL b2b_cmd c=%0d: got %b expected %b", c, obs, exp);
            end
          end else if (last_v >= 0 && c == last_v + 1) begin
            n_cmp++;
            if ({busy_t, busy_e} !== 2'b00) begin
              n_bad++; $display("FAIL b2b_busy_drop: got %b expected 00", {busy_t, busy_e});
            end
          end
        end
      end
    join
    n_cmp++;
    if (nv !== 16 || (last_v - first_v) !== 15) begin
      n_bad++; $display("FAIL b2b_contiguous: got %0d cmds span %0d expected 16 span 15", nv, last_v - first_v + 1);
    end
  endtask

  task automatic test_full();
    logic [11:0] obs, exp;
    logic [7:0] bytes [5];
    bit freed;
    bytes[0] = 8'h12; bytes[1] = 8'h34; bytes[2] = 8'h56; bytes[3] = 8'h78; bytes[4] = 8'h9A;
    freed = 1'b0;
    fork
      begin
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          n_cmp++;
          if ({ready_t, ready_e} !== 2'b11) begin
            n_bad++; $display("FAIL full_ready_before_push%0d: got %b expected 11", k, {ready_t, ready_e});
          end
          in_valid = 1'b1; in_data = bytes[k]; push_expect(bytes[k], -1);
        end
        @(negedge clk);
        n_cmp++;
        if ({ready_t, ready_e} !== 2'b00) begin
          n_bad++; $display("FAIL full_ready_low: got %b expected 00", {ready_t, ready_e});
        end
        in_data = 8'hEE;
        @(negedge clk); in_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 56; c++) begin
          @(negedge clk);
          obs = observe();
          if (jv_t || jv_e) begin
            exp = (sb.size() > 0) ? sb.pop_front() : 12'h000;
            n_cmp++;
            if (obs !== exp) begin
              n_bad++; $display("FAIL full_cmd c=%0d: got %b expected %b", c, obs, exp);
            end
          end
          if (bd_t && !freed) begin
            freed = 1'b1;
            n_cmp++;
            if ({ready_t, ready_e} !== 2'b11) begin
              n_bad++; $display("FAIL full_ready_after_pop: got %b expected 11", {ready_t, ready_e});
            end
          end
        end
      end
    join
    n_cmp++;
    if (sb.size() !== 0 || !freed) begin
      n_bad++; $display("FAIL full_drain: got %0d left freed=%0d expected 0 left freed=1", sb.size(), freed);
    end
  endtask

  task automatic test_resync();
    logic [11:0] obs, exp;
    int nv;
    nv = 0;
    fork
      begin
        @(negedge clk); in_valid = 1'b1; in_data = 8'hFF; push_expect(8'hFF, 0);
        @(negedge clk); in_data = 8'h00; push_expect(8'h00, -1);
        @(negedge clk); in_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 26; c++) begin
          @(negedge clk);
          obs = observe();
          if (jv_t || jv_e) begin
            nv++;
            exp = (sb.size() > 0) ? sb.pop_front() : 12'h000;
            n_cmp++;
            if (obs !== exp) begin
              n_bad++; $display("FAIL resync_cmd c=%0d: got %b expected %b", c, obs, exp);
            end
            if (nv == 9) begin
              n_cmp++;
              if ({j_t, j_e} !== 4'b0101) begin
                n_bad++; $display("FAIL resync_first_zero: got %b expected 0101", {j_t, j_e});
              end
            end
          end
          // Hold resync high across the edge that issues bit 0 of the 0xFF byte
          resync = (nv == 7);
        end
      end
    join
    resync = 1'b0;
    n_cmp++;
    if (sb.size() !== 0) begin
      n_bad++; $display("FAIL resync_missing: got %0d left expected 0", sb.size());
    end
  endtask

  task automatic test_reset_mid_byte();
    logic [11:0] obs, exp;
    int nv;
    bit aborted, quiet_bad;
    nv = 0; aborted = 1'b0; quiet_bad = 1'b0;
    fork
      begin
        @(negedge clk); in_valid = 1'b1; in_data = 8'h3C; push_expect(8'h3C, -1);
        @(negedge clk); in_data = 8'h81; push_expect(8'h81, -1);
        @(negedge clk); in_data = 8'h7E; push_expect(8'h7E, -1);
        @(negedge clk); in_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 30 && !aborted; c++) begin
          @(negedge clk);
          obs = observe();
          if (jv_t || jv_e) begin
            nv++;
            exp = (sb.size() > 0) ? sb.pop_front() : 12'h000;
            n_cmp++;
            if (obs !== exp) begin
              n_bad++; $display("FAIL abort_cmd c=%0d: got %b expected %b", c, obs, exp);
            end
          end
          if (nv == 5) begin
            reset = 1'b0;
            #1;
            aborted = 1'b1;
            n_cmp++;
            if ({jv_t, j_t, jv_e, j_e} !== 6'b000000) begin
              n_bad++; $display("FAIL abort_immediate: got %b expected 000000", {jv_t, j_t, jv_e, j_e});
            end
          end
        end
      end
    join
    n_cmp++;
    if (!aborted) begin
      n_bad++; $display("FAIL abort_reached: got no bit-3 command expected one");
    end
    sb.delete();
    reset_model();
    @(negedge clk); reset = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (jv_t || jv_e || busy_t || busy_e) quiet_bad = 1'b1;
    end
    n_cmp++;
    if (quiet_bad) begin
      n_bad++; $display("FAIL abort_quiet: got activity after release expected none");
    end
    @(negedge clk); in_valid = 1'b1; in_data = 8'h5A; push_expect(8'h5A, -1);
    @(negedge clk); in_valid = 1'b0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      obs = observe();
      if (jv_t || jv_e) begin
        exp = (sb.size() > 0) ? sb.pop_front() : 12'h000;
        n_cmp++;
        if (obs !== exp) begin
          n_bad++; $display("FAIL post_reset_cmd c=%0d: got %b expected %b", c, obs, exp);
        end
      end
    end
    n_cmp++;
    if (sb.size() !== 0) begin
      n_bad++; $display("FAIL post_reset_missing: got %0d left expected 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_full();
    test_resync();
    test_reset_mid_byte();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/jk_command_encoder.md
JK_COMMAND_ENCODER -- requirements
Module: jk_command_encoder

Interface
REQ-001 Parameter DEPTH, default 4: pattern FIFO depth in bytes, power of two, at least 2.
REQ-002 Parameter USE_TOGGLE, default 1: 1 = a required change is issued as toggle; 0 = issued as explicit set or reset.
REQ-003 Port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-low reset.
REQ-005 Port in_valid  input  1  a pattern byte is offered.
REQ-006 Port in_data  input  8  desired flop value sequence, serialized MSB first.
REQ-007 Port in_ready  output  1  FIFO can accept a byte; defined as not full.
REQ-008 Port resync  input  1  single-cycle pulse; marks the driven flop state as unknown.
REQ-009 Port j  output  2  JK command: 00 hold, 01 reset to 0, 10 set to 1, 11 toggle.
REQ-010 Port j_valid  output  1  j carries a pattern-derived command this cycle.
REQ-011 Port model_q  output  1  tracked value of the driven flop after the current command.
REQ-012 Port byte_done  output  1  one-cycle pulse coinciding with the command for bit 0 of a byte.
REQ-013 Port busy  output  1  high in SHIFT state or when the FIFO is non-empty.

Function
REQ-014 A byte is accepted on any rising edge with in_valid=1 and in_ready=1; in_ready stays low when full, even if a pop occurs in the same cycle.
REQ-015 The state machine has states IDLE and SHIFT.
REQ-016 IDLE with FIFO non-empty: the head byte is popped into an 8-bit shift register and the state moves to SHIFT on that edge.
REQ-017 SHIFT lasts exactly 8 cycles; in each cycle, j and j_valid=1 are registered outputs derived from shift-register bits 7 down to 0.
REQ-018 Latency: a byte pushed at edge N into an empty idle block produces its first command at edge N+2.
REQ-019 In the bit-0 cycle, if the FIFO is non-empty, the next byte is popped so its bit 7 follows at the next edge with no gap; otherwise the state returns to IDLE.
REQ-020 Command selection for desired bit d with model known:
- d equal to model_q gives 00;
- otherwise 11 if USE_TOGGLE=1, else 10 when d=1 and 01 when d=0.
REQ-021 While the model is unknown, the next command is always explicit: 10 when d=1, 01 when d=0; issuing it makes the model known.
REQ-022 model_q updates on the same edge as j: 01 gives 0, 10 gives 1, 11 gives the inverted value, 00 leaves it unchanged.
REQ-023 When j_valid=0, j=00 and model_q holds.
REQ-024 resync makes the model unknown from the next command onward; if asserted in the same cycle as a command, that command is still emitted as computed.

Reset
REQ-025 When reset=0:
- j=00, j_valid=0, byte_done=0;
- model_q=0 with the model unknown;
- FIFO empty, shift register cleared, state IDLE;
- in_ready=1 and busy=0.
REQ-026 Reset asserted mid-byte aborts the byte immediately; remaining bits and all queued bytes are discarded.
REQ-027 After reset release, operation resumes from IDLE at the first rising edge.

Verification
REQ-028 Reset, then push 0xA5 with USE_TOGGLE=1 -> j = 10,11,11,11,00,11,11,11 on 8 consecutive cycles; model_q ends at 1; byte_done high on the 8th cycle only.
REQ-029 Same stimulus with USE_TOGGLE=0 -> j = 10,01,10,01,00,10,01,10.
REQ-030 Push 0xA5 then 0xFF on back-to-back cycles -> 16 consecutive j_valid cycles; the 0xFF commands are all 00; busy drops 1 cycle after the last command.
REQ-031 With DEPTH=4, push on 5 consecutive edges -> in_ready=0 after the 5th accepted push; the 6th offered byte is not accepted; in_ready returns to 1 after the next pop.
REQ-032 Push 0x00 after 0xFF with resync pulsed during the 0xFF byte -> first 0x00 command is 01, the rest 00.
REQ-033 Assert reset during bit 3 of a byte with 2 bytes queued -> j=00, j_valid=0 immediately; no commands after release until a new push.
